mem_bus_responder: RTL

//   Target-side responder for the single-cycle addr/wr/en request bus that the

---
 rtl/mem_bus_pkg.sv | 16 +
 rtl/mem_bus_regfile.sv | 42 ++++
 rtl/mem_bus_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus responder.
// Included first by every mem_bus_* file.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int WR_CNT_W   = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_bus_regfile.sv
// DEPTH x DATA_W storage, async clear, one write port and
// one registered read port that can return zero instead of data.
module mem_bus_regfile
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rmask,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Masked reads answer out-of-range requests with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rmask ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Target-side responder: accepts one request at a time, inserts
// WAIT_CYC wait states, then commits the write or returns read data.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = 48,
  parameter int WAIT_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                err,
  output logic [WR_CNT_W-1:0] wr_count
);

  localparam logic [ADDR_W:0] DEPTH_L =
    (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              idle;
  logic              fire;
  logic              in_rng;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  // With zero wait states the response edge is the accept edge,
  // so the live bus stands in for the not-yet-latched request.
  always_comb begin
    idle      = (state == IDLE);
    cur_wr    = idle ? wr    : wr_q;
    cur_addr  = idle ? addr  : addr_q;
    cur_wdata = idle ? wdata : wdata_q;
    in_rng    = ({1'b0, cur_addr} < DEPTH_L);
    ready     = idle;
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) begin
          if (WAIT_CYC == 0) begin
            state_nxt = RESP;
            fire      = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          fire      = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
      wr_count <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= fire && !cur_wr;
      err    <= fire && !in_rng;
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= CNT_INIT;
      end
      if (idle && en) begin
        wr_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (fire && cur_wr && in_rng && (wr_count != '1)) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  mem_bus_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (fire && cur_wr && in_rng),
    .waddr (cur_addr),
    .wdata (cur_wdata),
    .re    (fire && !cur_wr),
    .rmask (!in_rng),
    .raddr (cur_addr),
    .rdata (rdata)
  );

endmodule
